// File: rtl/line_buffer_fifo.sv
// Line FIFO for the scaler: holds NUM_LINES video lines and exposes two adjacent completed rows, two taps each.
// Latency: tap data is registered, valid one cycle after the address (uses the pre-advance read pointer).
// Backpressure: none on the ports; writes or advances while full, and advances beyond fillCount, are dropped and set sticky flags.
//
// Ports:
//   clk, rst (async active-low)          clocking and reset
//   writeData/writeAddress/writeEnable   pixel write into the current write line
//   advanceWrite                         current write line complete
//   advanceRead1/advanceRead2            release 1 or 2 lines (2 wins)
//   clearErrors                          clear overflow/underflow
//   readAddress0x/1x, readData0x/1x      taps into row 0 (oldest line) and row 1
//   fillCount/full/rowsValid             occupancy status
//   overflow/underflow                   sticky error flags
module line_buffer_fifo #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 11,
    parameter int NUM_LINES     = 4,
    parameter int FILL_WIDTH    = $clog2(NUM_LINES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    writeData,
    input  logic [ADDRESS_WIDTH-1:0] writeAddress,
    input  logic                     writeEnable,
    input  logic                     advanceWrite,
    input  logic                     advanceRead1,
    input  logic                     advanceRead2,
    input  logic                     clearErrors,
    input  logic [ADDRESS_WIDTH-1:0] readAddress00,
    input  logic [ADDRESS_WIDTH-1:0] readAddress01,
    input  logic [ADDRESS_WIDTH-1:0] readAddress10,
    input  logic [ADDRESS_WIDTH-1:0] readAddress11,
    output logic [DATA_WIDTH-1:0]    readData00,
    output logic [DATA_WIDTH-1:0]    readData01,
    output logic [DATA_WIDTH-1:0]    readData10,
    output logic [DATA_WIDTH-1:0]    readData11,
    output logic [FILL_WIDTH-1:0]    fillCount,
    output logic                     full,
    output logic                     rowsValid,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PTR_WIDTH = $clog2(NUM_LINES);
    localparam int LINE_LEN  = 2 ** ADDRESS_WIDTH;
    localparam logic [FILL_WIDTH-1:0] FILL_MAX  = FILL_WIDTH'(NUM_LINES);
    localparam logic [PTR_WIDTH:0]    LINES_EXT = (PTR_WIDTH + 1)'(NUM_LINES);

    // Line length is a power of two, so {line, pixel} is line*LINE_LEN + pixel
    // and never exceeds the array because the line pointer stays below NUM_LINES.
    logic [DATA_WIDTH-1:0] mem [NUM_LINES * LINE_LEN];

    logic [PTR_WIDTH-1:0]  write_ptr;
    logic [PTR_WIDTH-1:0]  read_ptr;
    logic [PTR_WIDTH-1:0]  row1_ptr;
    logic [1:0]            read_step;
    logic                  write_acc;
    logic                  read_acc;
    logic                  overflow_set;
    logic                  underflow_set;
    logic [FILL_WIDTH-1:0] fill_next;

    // Modulo-NUM_LINES increment by 0..2; one subtract suffices since ptr+2 < 2*NUM_LINES.
    function automatic logic [PTR_WIDTH-1:0] ptr_add(input logic [PTR_WIDTH-1:0] ptr,
                                                     input logic [1:0] inc);
        logic [PTR_WIDTH:0] sum;
        sum = {1'b0, ptr} + (PTR_WIDTH + 1)'(inc);
        if (sum >= LINES_EXT) begin
            sum = sum - LINES_EXT;
        end
        return sum[PTR_WIDTH-1:0];
    endfunction

    always_comb begin
        full      = (fillCount == FILL_MAX);
        rowsValid = (fillCount >= FILL_WIDTH'(2));
        read_step = 2'd0;
        if (advanceRead2) begin
            read_step = 2'd2;
        end else if (advanceRead1) begin
            read_step = 2'd1;
        end
        // Both sides judge acceptance on the pre-edge count.
        write_acc     = advanceWrite && !full;
        read_acc      = (read_step != 2'd0) && (fillCount >= FILL_WIDTH'(read_step));
        overflow_set  = full && (advanceWrite || writeEnable);
        underflow_set = (read_step != 2'd0) && !read_acc;
        fill_next     = fillCount + FILL_WIDTH'(write_acc)
                        - (read_acc ? FILL_WIDTH'(read_step) : '0);
        row1_ptr      = ptr_add(read_ptr, 2'd1);
    end

    // RAM has no reset; writes target the pre-advance write pointer.
    always_ff @(posedge clk) begin
        if (writeEnable && !full) begin
            mem[{write_ptr, writeAddress}] <= writeData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_ptr  <= '0;
            read_ptr   <= '0;
            fillCount  <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            readData00 <= '0;
            readData01 <= '0;
            readData10 <= '0;
            readData11 <= '0;
        end else begin
            if (write_acc) begin
                write_ptr <= ptr_add(write_ptr, 2'd1);
            end
            if (read_acc) begin
                read_ptr <= ptr_add(read_ptr, read_step);
            end
            fillCount <= fill_next;
            // A new error in the same cycle as a clear leaves the flag set.
            overflow  <= overflow_set  || (overflow  && !clearErrors);
            underflow <= underflow_set || (underflow && !clearErrors);
            readData00 <= mem[{read_ptr, readAddress00}];
            readData01 <= mem[{read_ptr, readAddress01}];
            readData10 <= mem[{row1_ptr, readAddress10}];
            readData11 <= mem[{row1_ptr, readAddress11}];
        end
    end

endmodule

// File: tb/tb_line_buffer_fifo.sv
module tb_line_buffer_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // Default-parameter instance (16-bit pixels, 2048-pixel lines, 4 lines).
    logic [15:0] writeData = '0;
    logic [10:0] writeAddress = '0;
    logic        writeEnable = 1'b0, advanceWrite = 1'b0;
    logic        advanceRead1 = 1'b0, advanceRead2 = 1'b0, clearErrors = 1'b0;
    logic [10:0] readAddress00 = '0, readAddress01 = '0, readAddress10 = '0, readAddress11 = '0;
    logic [15:0] readData00, readData01, readData10, readData11;
    logic [2:0]  fillCount;
    logic        full, rowsValid, overflow, underflow;

    // Five-line, 16-pixel instance for pointer wrap.
    logic [15:0] b_writeData = '0;
    logic [3:0]  b_writeAddress = '0;
    logic        b_writeEnable = 1'b0, b_advanceWrite = 1'b0;
    logic        b_advanceRead1 = 1'b0, b_advanceRead2 = 1'b0, b_clearErrors = 1'b0;
    logic [3:0]  b_readAddress00 = '0, b_readAddress01 = '0, b_readAddress10 = '0, b_readAddress11 = '0;
    logic [15:0] b_readData00, b_readData01, b_readData10, b_readData11;
    logic [2:0]  b_fillCount;
    logic        b_full, b_rowsValid, b_overflow, b_underflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    line_buffer_fifo dut (
        .clk(clk), .rst(rst),
        .writeData(writeData), .writeAddress(writeAddress), .writeEnable(writeEnable),
        .advanceWrite(advanceWrite), .advanceRead1(advanceRead1), .advanceRead2(advanceRead2),
        .clearErrors(clearErrors),
        .readAddress00(readAddress00), .readAddress01(readAddress01),
        .readAddress10(readAddress10), .readAddress11(readAddress11),
        .readData00(readData00), .readData01(readData01),
        .readData10(readData10), .readData11(readData11),
        .fillCount(fillCount), .full(full), .rowsValid(rowsValid),
        .overflow(overflow), .underflow(underflow)
    );

    line_buffer_fifo #(.DATA_WIDTH(16), .ADDRESS_WIDTH(4), .NUM_LINES(5)) dut5 (
        .clk(clk), .rst(rst),
        .writeData(b_writeData), .writeAddress(b_writeAddress), .writeEnable(b_writeEnable),
        .advanceWrite(b_advanceWrite), .advanceRead1(b_advanceRead1), .advanceRead2(b_advanceRead2),
        .clearErrors(b_clearErrors),
        .readAddress00(b_readAddress00), .readAddress01(b_readAddress01),
        .readAddress10(b_readAddress10), .readAddress11(b_readAddress11),
        .readData00(b_readData00), .readData01(b_readData01),
        .readData10(b_readData10), .readData11(b_readData11),
        .fillCount(b_fillCount), .full(b_full), .rowsValid(b_rowsValid),
        .overflow(b_overflow), .underflow(b_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample and drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        writeEnable  = 1'b0;
        advanceWrite = 1'b0;
        advanceRead1 = 1'b0;
        advanceRead2 = 1'b0;
        clearErrors  = 1'b0;
    endtask

    // Full line with pixel = base + address; the last pixel shares its cycle with advanceWrite.
    task automatic write_line(input logic [15:0] base);
        for (int i = 0; i < 2048; i++) begin
            writeEnable  = 1'b1;
            writeAddress = 11'(i);
            writeData    = base + 16'(i);
            advanceWrite = (i == 2047);
            tick();
        end
        idle();
    endtask

    task automatic write_pixel_and_close(input logic [10:0] addr, input logic [15:0] data);
        writeEnable = 1'b1; writeAddress = addr; writeData = data;
        tick();
        idle();
        advanceWrite = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_fill", 32'(fillCount), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_rows_valid", 32'(rowsValid), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_underflow", 32'(underflow), 0);
        chk("rst_rd00", 32'(readData00), 0);
        chk("rst_rd11", 32'(readData11), 0);
        #10 rst = 1'b1;
        tick();

        // Two full lines, then taps at 5/6 on both rows
        write_line(16'h0000);
        write_line(16'h0100);
        chk("two_lines_fill", 32'(fillCount), 2);
        chk("two_lines_rows_valid", 32'(rowsValid), 1);
        chk("two_lines_full", 32'(full), 0);
        readAddress00 = 11'd5; readAddress01 = 11'd6;
        readAddress10 = 11'd5; readAddress11 = 11'd6;
        tick();
        chk("tap00", 32'(readData00), 32'h0005);
        chk("tap01", 32'(readData01), 32'h0006);
        chk("tap10", 32'(readData10), 32'h0105);
        chk("tap11", 32'(readData11), 32'h0106);
        readAddress01 = 11'd2047; readAddress11 = 11'd2047;
        tick();
        chk("last_pixel_row0", 32'(readData01), 32'h07FF);
        chk("last_pixel_row1", 32'(readData11), 32'h08FF);

        // Fill to 4, then overflow with advanceWrite + writeEnable (target would be line 0)
        write_pixel_and_close(11'd5, 16'h0205);
        write_pixel_and_close(11'd5, 16'h0305);
        chk("full_fill", 32'(fillCount), 4);
        chk("full_flag", 32'(full), 1);
        chk("full_no_overflow_yet", 32'(overflow), 0);
        advanceWrite = 1'b1; writeEnable = 1'b1; writeAddress = 11'd5; writeData = 16'hDEAD;
        tick();
        idle();
        chk("ovf_fill", 32'(fillCount), 4);
        chk("ovf_flag", 32'(overflow), 1);
        tick();
        chk("ovf_line0_intact", 32'(readData00), 32'h0005);

        // Full with simultaneous write and read advance
        advanceWrite = 1'b1; advanceRead1 = 1'b1;
        tick();
        idle();
        chk("full_rw_fill", 32'(fillCount), 3);
        chk("full_rw_full", 32'(full), 0);
        chk("full_rw_overflow", 32'(overflow), 1);
        tick();
        chk("rptr1_row0", 32'(readData00), 32'h0105);
        chk("rptr1_row1", 32'(readData10), 32'h0205);
        // Write pointer must still be 0: next line lands in line 0, read as row 1 from readPtr 3
        write_pixel_and_close(11'd7, 16'hAA07);
        chk("refill_fill", 32'(fillCount), 4);
        advanceRead2 = 1'b1;
        tick();
        idle();
        chk("adv2_fill", 32'(fillCount), 2);
        readAddress10 = 11'd7;
        tick();
        chk("rptr3_row0", 32'(readData00), 32'h0305);
        chk("rptr3_row1_wrap", 32'(readData10), 32'hAA07);
        clearErrors = 1'b1;
        tick();
        idle();
        chk("ovf_cleared", 32'(overflow), 0);

        // Underflow and clear
        advanceRead1 = 1'b1;
        tick();
        idle();
        chk("one_line_fill", 32'(fillCount), 1);
        chk("one_line_rows_valid", 32'(rowsValid), 0);
        chk("one_line_underflow", 32'(underflow), 0);
        advanceRead2 = 1'b1;
        tick();
        idle();
        chk("udf_fill", 32'(fillCount), 1);
        chk("udf_flag", 32'(underflow), 1);
        clearErrors = 1'b1;
        tick();
        idle();
        chk("udf_cleared", 32'(underflow), 0);
        clearErrors = 1'b1; advanceRead2 = 1'b1;
        tick();
        idle();
        chk("udf_clear_and_set", 32'(underflow), 1);
        chk("udf_clear_and_set_fill", 32'(fillCount), 1);
        clearErrors = 1'b1;
        tick();
        idle();

        // Empty with simultaneous write and read advance
        advanceRead1 = 1'b1;
        tick();
        idle();
        chk("empty_fill", 32'(fillCount), 0);
        advanceWrite = 1'b1; advanceRead1 = 1'b1;
        tick();
        idle();
        chk("empty_rw_fill", 32'(fillCount), 1);
        chk("empty_rw_underflow", 32'(underflow), 1);

        // Reach 3 lines, then reset asynchronously mid-line
        advanceWrite = 1'b1;
        tick();
        tick();
        idle();
        chk("pre_reset_fill", 32'(fillCount), 3);
        writeEnable = 1'b1; writeAddress = 11'd9; writeData = 16'h7777;
        #3 rst = 1'b0;
        #1;
        chk("arst_fill", 32'(fillCount), 0);
        chk("arst_full", 32'(full), 0);
        chk("arst_rows_valid", 32'(rowsValid), 0);
        chk("arst_underflow", 32'(underflow), 0);
        chk("arst_overflow", 32'(overflow), 0);
        chk("arst_rd00", 32'(readData00), 0);
        chk("arst_rd10", 32'(readData10), 0);
        idle();
        #12 rst = 1'b1;
        tick();
        readAddress00 = 11'd9;
        write_pixel_and_close(11'd9, 16'h1239);
        chk("post_reset_fill", 32'(fillCount), 1);
        tick();
        chk("post_reset_line0", 32'(readData00), 32'h1239);
        chk("post_reset_rows_valid", 32'(rowsValid), 0);

        // Five-line instance: 12 rounds of two writes then advanceRead2, pointers wrap 4->1
        b_readAddress00 = 4'd3; b_readAddress01 = 4'd3;
        b_readAddress10 = 4'd3; b_readAddress11 = 4'd3;
        for (int it = 0; it < 12; it++) begin
            for (int j = 0; j < 2; j++) begin
                b_writeEnable = 1'b1; b_writeAddress = 4'd3;
                b_writeData = 16'(((2 * it + j) << 4) | 3);
                tick();
                b_writeEnable = 1'b0; b_advanceWrite = 1'b1;
                tick();
                b_advanceWrite = 1'b0;
            end
            tick();
            chk("wrap_fill", 32'(b_fillCount), 2);
            chk("wrap_row0", 32'(b_readData00), 32'(((2 * it) << 4) | 3));
            chk("wrap_row0_tap1", 32'(b_readData01), 32'(((2 * it) << 4) | 3));
            chk("wrap_row1", 32'(b_readData10), 32'(((2 * it + 1) << 4) | 3));
            b_advanceRead2 = 1'b1;
            tick();
            b_advanceRead2 = 1'b0;
        end
        chk("wrap_final_fill", 32'(b_fillCount), 0);
        chk("wrap_no_underflow", 32'(b_underflow), 0);
        chk("wrap_no_overflow", 32'(b_overflow), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
